// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: merges NUM_IN sop/eop framed valid/ready
// streams into one registered output stream without interleaving packets.
module pkt_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 20,
  parameter int IDX_W      = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_sop,
  input  logic [NUM_IN-1:0]            in_eop,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [IDX_W-1:0]             out_src,
  output logic                         busy,
  output logic [31:0]                  pkt_cnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        grant, grant_nxt;
  logic [IDX_W-1:0]        last_grant, last_grant_nxt;
  logic [IDX_W-1:0]        pick;
  logic                    pick_found;
  logic                    stage_free;
  logic                    accept;
  logic                    sel_valid, sel_sop, sel_eop;
  logic [DATA_WIDTH-1:0]   sel_data;

  // Round-robin scan starting just after the previous packet's owner.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 1; i <= NUM_IN; i++) begin
      idx = (int'(last_grant) + i) % NUM_IN;
      if (!pick_found && in_valid[idx]) begin
        pick       = IDX_W'(idx);
        pick_found = 1'b1;
      end
    end
  end

  assign sel_valid  = in_valid[grant];
  assign sel_sop    = in_sop[grant];
  assign sel_eop    = in_eop[grant];
  assign sel_data   = in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign stage_free = !out_valid || out_ready;
  assign accept     = (state == LOCKED) && sel_valid && stage_free;
  assign busy       = (state == LOCKED);

  always_comb begin
    in_ready = '0;
    if (state == LOCKED) in_ready[grant] = stage_free;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        // The grant is released only by an accepted eop beat.
        if (accept && sel_eop) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_IN - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // A load in the same cycle as a drain keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sop   <= sel_sop;
      out_eop   <= sel_eop;
      out_src   <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (out_valid && out_ready && out_eop) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

endmodule

// File: doc/pkt_rr_arbiter.md
# pkt_rr_arbiter

Packet-granular round-robin arbiter that merges `NUM_IN` valid/ready packet streams (sop/eop framed) into one output stream feeding a shared packet FIFO wrapper. A grant is held from the first accepted beat of a packet through its eop beat, so packets are never interleaved. The output is registered, and the block sustains one beat per cycle inside a packet.

## Interface
Parameters:
- `NUM_IN`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 20: beat payload width.
- `IDX_W`, `$clog2(NUM_IN)`: grant index width. Derived; do not override.

Ports:
- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input `NUM_IN`: per-requester beat valid.
- `in_ready` output `NUM_IN`: per-requester ready. At most one bit is set.
- `in_data` input `NUM_IN*DATA_WIDTH`: requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_sop` input `NUM_IN`: start-of-packet flags.
- `in_eop` input `NUM_IN`: end-of-packet flags.
- `out_valid` output 1: registered beat valid.
- `out_ready` input 1: downstream ready (FIFO not full).
- `out_data` output `DATA_WIDTH`: registered beat payload.
- `out_sop` output 1: registered start-of-packet flag.
- `out_eop` output 1: registered end-of-packet flag.
- `out_src` output `IDX_W`: requester index of the current output beat.
- `busy` output 1: high while in LOCKED.
- `pkt_cnt` output 32: packets forwarded (eop beats accepted downstream); wraps.

## Operation
- State machine has two states:
  - IDLE: `in_ready` = 0. If any `in_valid` is set, pick the first set bit scanning upward from `last_grant+1` modulo `NUM_IN`. Register it into `grant` and go to LOCKED. With no request, stay in IDLE.
  - LOCKED: `in_ready[grant]` = `stage_free`; all other `in_ready` bits are 0. `stage_free` = `!out_valid || out_ready`.
    - Beat accept: `in_valid[grant] && in_ready[grant]`. On accept, the output register loads data, sop, eop and `src=grant`, and sets `out_valid`.
    - If the accepted beat has eop, set `last_grant` = `grant` and go to IDLE.
- Output register:
  - On `out_valid && out_ready` with no new load, `out_valid` clears.
  - If a load and a drain happen in the same cycle, the load wins and `out_valid` stays 1.
- `pkt_cnt` increments by 1 on `out_valid && out_ready && out_eop`.
- sop is not checked. A beat accepted in LOCKED is forwarded unchanged. A single-beat packet (sop=eop=1) locks and releases in one accept.
- A requester that drops `in_valid` mid-packet keeps the grant. The arbiter waits indefinitely; there is no timeout.
- Requester data width and `out_data` width are equal. No truncation or padding.

## Timing
- Reset values:
  - state = IDLE, `grant` = 0, `last_grant` = `NUM_IN-1` (requester 0 has first priority).
  - `out_valid`, `out_sop`, `out_eop` = 0.
  - `out_data` = 0, `out_src` = 0, `pkt_cnt` = 0.
  - `busy` = 0, `in_ready` = 0.
- Reset asserted mid-packet aborts at once: a partial packet is lost and the pending output beat is dropped.
- Arbitration latency:
  - Request seen in IDLE at cycle t gives LOCKED at t+1, first accept at t+1 if `stage_free`, and `out_valid` at t+2.
- Inter-packet gap:
  - eop accepted at cycle e leads to IDLE at e+1 and next accept at e+2.
  - This is exactly one dead input cycle per packet.
- Throughput inside a packet is 1 beat/cycle while `out_ready` = 1.
- `in_ready` depends combinationally on `out_ready`. No other combinational input-to-output paths exist.
- Back-pressure: while `out_valid` && !`out_ready`, the output register holds all fields stable and `in_ready` = 0.
- Rotation: if requester k is granted and all requesters are requesting, the next grant goes to (k+1) mod `NUM_IN`.

## Test plan
- Single requester:
  - Stimulus: port 2 sends a 3-beat packet (data 0xA1, 0xA2, 0xA3) with `out_ready`=1.
  - Response: the output shows the beats at cycles t+2..t+4 with sop on beat 1, eop on beat 3, `out_src`=2, and `pkt_cnt`=1.
- Fairness:
  - Stimulus: all 4 ports continuously offer 2-beat packets, for 8 packets.
  - Response: the source order is 0,1,2,3,0,1,2,3 with no interleaving inside any packet.
- Lock hold:
  - Stimulus: port 1 pauses `in_valid` for 5 cycles mid-packet while port 0 requests.
  - Response: `in_ready[0]` stays 0 until port 1's eop is accepted, and the next grant is then port 2 if it is requesting, else port 0.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 for 4 cycles mid-packet.
  - Response: `out_data`, `out_sop` and `out_eop` stay stable, no beat is lost or duplicated, and streaming resumes at one beat/cycle.
- Single-beat packets:
  - Stimulus: ports 0 and 3 alternate sop=eop=1 beats.
  - Response: each beat is forwarded with one idle input cycle between beats, and `pkt_cnt` increments per beat.
- Async reset:
  - Stimulus: assert `rst` in the middle of a packet, between clock edges.
  - Response: `out_valid`, `busy` and `in_ready` drop immediately, `pkt_cnt`=0, and after release port 0 gets first priority.
